neuron_update_scheduler: RTL and testbench
==========================================

# neuron_update_scheduler

Time-multiplexes the NeuroCore's single shared LIF neuron-update datapath across all neurons once per timestep. On each `tick` it issues one update request per neuron index, in ascending order, through a valid/ready/done handshake. It collects each neuron's spike result and publishes the full spike vector atomically at the end of the step. It sits between the timestep generator and the membrane-update datapath inside `tt_um_NeuroCore`.

## Interface
Parameters:
- `NUM_NEURONS`, 8: neurons served per timestep; must be ≥2.
- `IDX_W`, 3: index width; must satisfy 2^IDX_W ≥ NUM_NEURONS.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-high.
- `en`, in, 1: when low, `tick` is ignored in IDLE; a step already in progress runs to completion.
- `tick`, in, 1: timestep start; 1-cycle pulse.
- `upd_valid`, out, 1: update request to the datapath.
- `upd_idx`, out, IDX_W: neuron index of the current request.
- `upd_ready`, in, 1: datapath accepts the request.
- `upd_done`, in, 1: datapath finished the accepted update.
- `upd_spike`, in, 1: spike result; sampled only together with `upd_done`.
- `spike_vec`, out, NUM_NEURONS: committed spikes of the last completed step.
- `step_done`, out, 1: 1-cycle pulse, high while in COMMIT.
- `busy`, out, 1: high whenever the state is not IDLE.
- `step_cnt`, out, 8: count of completed timesteps; wraps 255→0.
- `overrun`, out, 1: sticky error flag; set by a `tick` that arrives while `busy`.
- `clr_err`, in, 1: clears `overrun`.

## Operation
- States: IDLE, ISSUE, WAIT, COMMIT.
- IDLE: if `tick && en`, then `idx`←0, shadow vector←0, go to ISSUE. Otherwise stay in IDLE.
- ISSUE: `upd_valid`=1 and `upd_idx`=`idx`. Hold both stable until `upd_ready`=1, then go to WAIT.
- WAIT: `upd_valid`=0. Wait for `upd_done`=1, then:
  - set `shadow[idx]` ← `upd_spike`;
  - if `idx` == NUM_NEURONS−1: `spike_vec` ← shadow with the new bit merged in, go to COMMIT;
  - else: `idx`++, go to ISSUE.
- `upd_done` outside WAIT is ignored.
- COMMIT: `step_done`=1, `step_cnt`++ (modulo 256), go to IDLE.
- `tick` while not in IDLE:
  - the tick is dropped and `overrun`←1;
  - the running step is unaffected.
- `clr_err` clears `overrun`. If `clr_err` and an overrunning `tick` occur in the same cycle, set wins.
- `upd_idx` holds its last value outside ISSUE. `upd_idx` is meaningful only while `upd_valid` is high.
- `spike_vec` changes only on the edge entering COMMIT. It is never partially updated.

## Timing
- Reset values:
  - state=IDLE;
  - `upd_valid`=0, `upd_idx`=0, `spike_vec`=0, `step_done`=0, `busy`=0, `step_cnt`=0, `overrun`=0;
  - internal `idx`=0, shadow=0.
- `upd_valid`, `busy` and `step_done` are decoded from registered state. They contain no combinational path from inputs.
- Minimum handshake: `upd_ready` high in the first ISSUE cycle, `upd_done` high in the first WAIT cycle. This costs 2 cycles per neuron.
- Tick sampled at edge E0:
  - first `upd_valid` is visible in cycle E0+1;
  - `step_done` is high in cycle E0+2·NUM_NEURONS+1;
  - `busy` falls in the following cycle.
- A `tick` in the COMMIT cycle counts as overrun. The earliest accepted next tick is the first cycle back in IDLE.
- Reset asserted mid-step: all state returns to reset values immediately.
  - `spike_vec` clears to 0.
  - The partial step is discarded and no `step_done` is generated.
  - After release, the block stays in IDLE until a new `tick` arrives.
- Datapath stalls (`upd_ready` or `upd_done` held low) extend ISSUE or WAIT indefinitely. There is no timeout.

## Test plan
- Reset, then `tick` with `upd_ready`=1 and `upd_done` one cycle after each accept, `upd_spike`=1 for indices 1 and 6 -> `upd_idx` sequence 0..7, `step_done` at E0+17, `spike_vec`=8'b0100_0010, `step_cnt`=1.
- Hold `upd_ready` low for 3 cycles on index 2 -> `upd_valid` stays high with `upd_idx`=2 throughout, no index skipped, `step_done` delayed by exactly 3 cycles.
- Second `tick` while `busy` -> `overrun`=1, step completes normally, `step_cnt` increments once; then `clr_err` -> `overrun`=0.
- `en`=0 with `tick` in IDLE -> no `upd_valid`, `busy` stays 0. `en` dropped mid-step -> step still completes and asserts `step_done`.
- Assert `rst` during WAIT for index 4 after a prior step left `spike_vec`=8'hFF -> all outputs return to reset values immediately (`spike_vec`=0, `step_cnt`=0), no `step_done`.
- Run 256 consecutive steps -> `step_cnt` wraps to 0; stray `upd_done` pulses injected during IDLE and ISSUE -> spike results unchanged.

Source files
------------

// File: rtl/neuron_update_scheduler.sv
// Shares one LIF update datapath across all neurons per timestep.
// Issues idx 0..N-1 on tick and commits the spike vector at step end.
//
// Ports:
//   clk, rst       : clock, async active-high reset
//   en, tick       : step enable, timestep start pulse
//   upd_valid/idx  : update request to the datapath
//   upd_ready      : datapath accepts request
//   upd_done/spike : datapath finished, spike result
//   spike_vec      : committed spikes of last completed step
//   step_done      : pulse while committing
//   busy           : high outside IDLE
//   step_cnt       : completed steps, wraps at 256
//   overrun        : sticky, tick seen while busy
//   clr_err        : clears overrun (an overrunning tick wins)
module neuron_update_scheduler #(
   parameter int NUM_NEURONS = 8,
   parameter int IDX_W       = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   tick,
   output logic                   upd_valid,
   output logic [IDX_W-1:0]       upd_idx,
   input  logic                   upd_ready,
   input  logic                   upd_done,
   input  logic                   upd_spike,
   output logic [NUM_NEURONS-1:0] spike_vec,
   output logic                   step_done,
   output logic                   busy,
   output logic [7:0]             step_cnt,
   output logic                   overrun,
   input  logic                   clr_err
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_COMMIT = 2'd3;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

   logic [1:0]             state;
   logic [IDX_W-1:0]       idx;
   logic [NUM_NEURONS-1:0] shadow;
   logic [NUM_NEURONS-1:0] merged;

   // Shadow with the current result folded in, so the last
   // neuron's bit lands in spike_vec on the same edge.
   always_comb begin
      merged      = shadow;
      merged[idx] = upd_spike;
   end

   // idx only moves on entry to ISSUE, so it already holds
   // its last value everywhere else.
   assign upd_idx   = idx;
   assign upd_valid = (state == S_ISSUE);
   assign busy      = (state != S_IDLE);
   assign step_done = (state == S_COMMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         idx       <= '0;
         shadow    <= '0;
         spike_vec <= '0;
         step_cnt  <= '0;
         overrun   <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (tick && en) begin
                  idx    <= '0;
                  shadow <= '0;
                  state  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (upd_ready)
                  state <= S_WAIT;
            end
            S_WAIT: begin
               if (upd_done) begin
                  shadow <= merged;
                  if (idx == LAST_IDX) begin
                     spike_vec <= merged;
                     state     <= S_COMMIT;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= S_ISSUE;
                  end
               end
            end
            S_COMMIT: begin
               step_cnt <= step_cnt + 8'd1;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // A tick in any non-IDLE state is dropped and flagged.
         if (tick && (state != S_IDLE))
            overrun <= 1'b1;
         else if (clr_err)
            overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Self-checking bench for neuron_update_scheduler.
// Acts as the datapath and checks against a step-level model.
module tb_neuron_update_scheduler;

   localparam int NN = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          tick;
   logic          upd_valid;
   logic [IW-1:0] upd_idx;
   logic          upd_ready;
   logic          upd_done;
   logic          upd_spike;
   logic [NN-1:0] spike_vec;
   logic          step_done;
   logic          busy;
   logic [7:0]    step_cnt;
   logic          overrun;
   logic          clr_err;

   neuron_update_scheduler #(
      .NUM_NEURONS(NN),
      .IDX_W      (IW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .tick      (tick),
      .upd_valid (upd_valid),
      .upd_idx   (upd_idx),
      .upd_ready (upd_ready),
      .upd_done  (upd_done),
      .upd_spike (upd_spike),
      .spike_vec (spike_vec),
      .step_done (step_done),
      .busy      (busy),
      .step_cnt  (step_cnt),
      .overrun   (overrun),
      .clr_err   (clr_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Per-neuron datapath latencies and side stimulus for a step.
   int rd [NN];
   int dd [NN];
   int tick_at   = -1;
   int clr_at    = -1;
   int en_off_at = -1;

   // Step-level reference state.
   logic [NN-1:0] m_vec = '0;
   int            m_cnt = 0;
   bit            m_ovr = 1'b0;

   typedef struct {
      logic [NN-1:0] spk;
      int            stall_idx;
      int            stall_len;
      int            dlat;
      int            exp_done;
      logic [NN-1:0] exp_vec;
   } vec_t;

   vec_t tbl [5];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive_side(input int cyc);
      tick    = (cyc == tick_at);
      clr_err = (cyc == clr_at);
      if (cyc == en_off_at)
         en = 1'b0;
      if (tick)
         m_ovr = 1'b1;
      else if (clr_err)
         m_ovr = 1'b0;
   endtask

   task automatic zero_lat();
      for (int i = 0; i < NN; i++) begin
         rd[i] = 0;
         dd[i] = 0;
      end
   endtask

   // One timestep: tick, serve every request, check the commit.
   // abort_idx >= 0 asserts reset in the last WAIT cycle of that
   // neuron and returns early.
   task automatic run_step(input logic [NN-1:0] spk, input bit stray,
                           input int abort_idx, output int lat);
      int cyc;
      bit ok;
      int exp_lat;
      exp_lat = 1;
      for (int i = 0; i < NN; i++)
         exp_lat += rd[i] + dd[i] + 2;
      ok  = 1'b1;
      lat = 0;
      if (stray) begin
         upd_done  = 1'b1;
         upd_spike = 1'b1;
         @(negedge clk);
         upd_done  = 1'b0;
         upd_spike = 1'b0;
      end
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      cyc  = 1;
      for (int i = 0; i < NN; i++) begin
         for (int k = 0; k <= rd[i]; k++) begin
            if (!upd_valid || upd_idx != IW'(i) || !busy ||
                step_done || spike_vec != m_vec)
               ok = 1'b0;
            upd_ready = (k == rd[i]);
            upd_done  = stray;
            upd_spike = ~spk[i];
            drive_side(cyc);
            @(negedge clk);
            cyc++;
         end
         upd_ready = 1'b0;
         upd_done  = 1'b0;
         for (int k = 0; k <= dd[i]; k++) begin
            if (upd_valid || !busy || step_done || spike_vec != m_vec)
               ok = 1'b0;
            if (i == abort_idx && k == dd[i]) begin
               rst     = 1'b1;
               tick    = 1'b0;
               clr_err = 1'b0;
               #1;
               chk("pre_abort_protocol", 32'(ok), 1);
               chk("abort_spike_vec", 32'(spike_vec), 0);
               chk("abort_step_cnt", 32'(step_cnt), 0);
               chk("abort_busy", 32'(busy), 0);
               chk("abort_valid", 32'(upd_valid), 0);
               chk("abort_step_done", 32'(step_done), 0);
               chk("abort_overrun", 32'(overrun), 0);
               chk("abort_idx", 32'(upd_idx), 0);
               m_vec = '0;
               m_cnt = 0;
               m_ovr = 1'b0;
               return;
            end
            upd_done  = (k == dd[i]);
            upd_spike = (k == dd[i]) ? spk[i] : ~spk[i];
            drive_side(cyc);
            @(negedge clk);
            cyc++;
         end
         upd_done  = 1'b0;
         upd_spike = 1'b0;
      end
      drive_side(cyc);
      lat = cyc;
      chk("protocol", 32'(ok), 1);
      chk("step_done", 32'(step_done), 1);
      chk("latency", cyc, exp_lat);
      m_vec = spk;
      chk("spike_vec", 32'(spike_vec), 32'(m_vec));
      @(negedge clk);
      tick    = 1'b0;
      clr_err = 1'b0;
      m_cnt   = (m_cnt + 1) % 256;
      chk("step_cnt", 32'(step_cnt), m_cnt);
      chk("busy_after", 32'(busy), 0);
      chk("done_after", 32'(step_done), 0);
      chk("overrun", 32'(overrun), 32'(m_ovr));
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      bit  ok;
      logic [NN-1:0] spk;
      bit  stray;

      tbl[0] = '{8'b0100_0010, -1, 0, 0, 17, 8'b0100_0010};
      tbl[1] = '{8'h5A,         2, 3, 0, 20, 8'h5A};
      tbl[2] = '{8'hFF,        -1, 0, 1, 25, 8'hFF};
      tbl[3] = '{8'h00,         7, 2, 2, 35, 8'h00};
      tbl[4] = '{8'h81,         0, 1, 0, 18, 8'h81};

      rst       = 1'b1;
      en        = 1'b1;
      tick      = 1'b0;
      upd_ready = 1'b0;
      upd_done  = 1'b0;
      upd_spike = 1'b0;
      clr_err   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(upd_valid), 0);
      chk("rst_idx", 32'(upd_idx), 0);
      chk("rst_spike_vec", 32'(spike_vec), 0);
      chk("rst_step_done", 32'(step_done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_step_cnt", 32'(step_cnt), 0);
      chk("rst_overrun", 32'(overrun), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 5; t++) begin
         for (int i = 0; i < NN; i++) begin
            rd[i] = (i == tbl[t].stall_idx) ? tbl[t].stall_len : 0;
            dd[i] = tbl[t].dlat;
         end
         run_step(tbl[t].spk, 1'b0, -1, lat);
         chk("tbl_latency", lat, tbl[t].exp_done);
         chk("tbl_spike_vec", 32'(spike_vec), 32'(tbl[t].exp_vec));
      end

      // Overrun mid-step, then clear in IDLE.
      zero_lat();
      tick_at = 5;
      run_step(8'h3C, 1'b0, -1, lat);
      tick_at = -1;
      clr_err = 1'b1;
      m_ovr   = 1'b0;
      @(negedge clk);
      clr_err = 1'b0;
      chk("clr_err", 32'(overrun), 0);

      // Tick during COMMIT is an overrun and starts nothing.
      tick_at = 17;
      run_step(8'hC3, 1'b0, -1, lat);
      chk("commit_tick_idle", 32'(upd_valid), 0);

      // Same-cycle set and clear: set wins.
      tick_at = 6;
      clr_at  = 6;
      run_step(8'h11, 1'b0, -1, lat);
      // Clear after the set within a step.
      tick_at = 3;
      clr_at  = 9;
      run_step(8'h22, 1'b0, -1, lat);
      tick_at = -1;
      clr_at  = -1;

      // en low blocks a tick in IDLE.
      en   = 1'b0;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      ok   = 1'b1;
      repeat (3) begin
         if (busy || upd_valid)
            ok = 1'b0;
         @(negedge clk);
      end
      chk("en_low_blocks", 32'(ok), 1);
      chk("en_low_no_ovr", 32'(overrun), 0);

      // en dropped mid-step still completes.
      en        = 1'b1;
      en_off_at = 3;
      run_step(8'h96, 1'b0, -1, lat);
      en_off_at = -1;
      en        = 1'b1;

      // Reset during WAIT of index 4 after an all-ones step.
      run_step(8'hFF, 1'b0, -1, lat);
      dd[4] = 1;
      run_step(8'hA5, 1'b0, 4, lat);
      dd[4] = 0;
      @(negedge clk);
      rst = 1'b0;
      ok  = 1'b1;
      repeat (4) begin
         if (busy || step_done || upd_valid || spike_vec != '0)
            ok = 1'b0;
         @(negedge clk);
      end
      chk("post_reset_idle", 32'(ok), 1);

      // 256 randomized steps wrap step_cnt back to 0.
      for (int s = 0; s < 256; s++) begin
         spk   = NN'($urandom);
         stray = 1'($urandom_range(0, 1));
         for (int i = 0; i < NN; i++) begin
            rd[i] = $urandom_range(0, 2);
            dd[i] = $urandom_range(0, 2);
         end
         run_step(spk, stray, -1, lat);
      end
      chk("wrap_step_cnt", 32'(step_cnt), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
